// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one single-precision adder among NUM_PORTS requesters.
// One operation is in flight at a time, and every output comes straight from a register.
module adder_arbiter #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned GW        = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [32*NUM_PORTS-1:0]  req_a,
   input  logic [32*NUM_PORTS-1:0]  req_b,
   input  logic [NUM_PORTS-1:0]     req_stb,
   output logic [NUM_PORTS-1:0]     req_ack,
   output logic [31:0]              res_z,
   output logic [NUM_PORTS-1:0]     res_stb,
   input  logic [NUM_PORTS-1:0]     res_ack,
   output logic [31:0]              adder_a,
   output logic                     adder_a_stb,
   input  logic                     adder_a_ack,
   output logic [31:0]              adder_b,
   output logic                     adder_b_stb,
   input  logic                     adder_b_ack,
   input  logic [31:0]              adder_z,
   input  logic                     adder_z_stb,
   output logic                     adder_z_ack,
   output logic                     busy,
   output logic [GW-1:0]            grant
);

   typedef enum logic [2:0] {StIdle, StAccept, StSendA, StSendB, StWaitZ, StPutZ} state_e;

   state_e               r_state;
   logic [GW-1:0]        r_grant;
   logic [NUM_PORTS-1:0] r_req_ack;
   logic [NUM_PORTS-1:0] r_res_stb;
   logic [31:0]          r_op_a;
   logic [31:0]          r_op_b;
   logic [31:0]          r_z;
   logic [31:0]          r_res_z;
   logic [31:0]          r_adder_a;
   logic [31:0]          r_adder_b;
   logic                 r_a_stb;
   logic                 r_b_stb;
   logic                 r_z_ack;
   logic                 r_busy;

   logic [2*NUM_PORTS-1:0] w_req2;
   logic [NUM_PORTS-1:0]   w_rot;
   int                     w_off;
   int unsigned            w_idx;
   logic [GW-1:0]          w_next;
   logic [31:0]            w_a_arr [NUM_PORTS];
   logic [31:0]            w_b_arr [NUM_PORTS];

   // Rotate requests so bit 0 is the port just after the last grant; lowest set bit wins.
   always_comb begin
      w_req2 = {req_stb, req_stb};
      w_rot  = NUM_PORTS'(w_req2 >> (32'(r_grant) + 32'd1));
      w_off  = 0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = i;
      end
      w_idx  = (32'(r_grant) + 32'd1 + 32'(w_off)) % NUM_PORTS;
      w_next = GW'(w_idx);
   end

   always_comb begin
      for (int j = 0; j < NUM_PORTS; j++) begin
         w_a_arr[j] = req_a[32*j +: 32];
         w_b_arr[j] = req_b[32*j +: 32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_grant   <= GW'(NUM_PORTS - 1);
         r_req_ack <= '0;
         r_res_stb <= '0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_z       <= '0;
         r_res_z   <= '0;
         r_adder_a <= '0;
         r_adder_b <= '0;
         r_a_stb   <= 1'b0;
         r_b_stb   <= 1'b0;
         r_z_ack   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (|req_stb) begin
                  r_grant <= w_next;
                  r_busy  <= 1'b1;
                  r_state <= StAccept;
               end
            end
            StAccept: begin
               if (r_req_ack[r_grant] && req_stb[r_grant]) begin
                  r_op_a    <= w_a_arr[r_grant];
                  r_op_b    <= w_b_arr[r_grant];
                  r_req_ack <= '0;
                  r_state   <= StSendA;
               end else begin
                  r_req_ack[r_grant] <= 1'b1;
               end
            end
            StSendA: begin
               if (r_a_stb && adder_a_ack) begin
                  r_a_stb <= 1'b0;
                  r_state <= StSendB;
               end else begin
                  r_adder_a <= r_op_a;
                  r_a_stb   <= 1'b1;
               end
            end
            StSendB: begin
               if (r_b_stb && adder_b_ack) begin
                  r_b_stb <= 1'b0;
                  r_state <= StWaitZ;
               end else begin
                  r_adder_b <= r_op_b;
                  r_b_stb   <= 1'b1;
               end
            end
            StWaitZ: begin
               if (r_z_ack && adder_z_stb) begin
                  r_z     <= adder_z;
                  r_z_ack <= 1'b0;
                  r_state <= StPutZ;
               end else begin
                  r_z_ack <= 1'b1;
               end
            end
            StPutZ: begin
               if (r_res_stb[r_grant] && res_ack[r_grant]) begin
                  r_res_stb <= '0;
                  r_busy    <= 1'b0;
                  r_state   <= StIdle;
               end else begin
                  r_res_z            <= r_z;
                  r_res_stb[r_grant] <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign req_ack     = r_req_ack;
   assign res_z       = r_res_z;
   assign res_stb     = r_res_stb;
   assign adder_a     = r_adder_a;
   assign adder_a_stb = r_a_stb;
   assign adder_b     = r_adder_b;
   assign adder_b_stb = r_b_stb;
   assign adder_z_ack = r_z_ack;
   assign busy        = r_busy;
   assign grant       = r_grant;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural adder, requester driver, and a scoreboard monitor
// that checks each delivered result against values computed from plain real arithmetic.
module tb_adder_arbiter;
   localparam int NP = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [32*NP-1:0] req_a, req_b;
   logic [NP-1:0]   req_stb, req_ack, res_stb, res_ack;
   logic [31:0]     res_z, adder_a, adder_b, adder_z;
   logic            adder_a_stb, adder_a_ack, adder_b_stb, adder_b_ack;
   logic            adder_z_stb, adder_z_ack, busy;
   logic [1:0]      grant;

   int checks = 0;
   int errors = 0;

   typedef struct { int port; logic [31:0] a; logic [31:0] b; } op_t;
   typedef struct { int port; logic [31:0] z; } res_t;
   op_t         pend[$];
   res_t        exp_q[$];
   int          exp_order[$];
   logic [NP-1:0] hold_mask;
   int          ack_cnt[NP];

   adder_arbiter #(.NUM_PORTS(NP), .GW(2)) dut (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_stb(req_stb),
      .req_ack(req_ack), .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
      .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
      .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
      .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
      .busy(busy), .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Single-precision <-> real for normal values; NaN handled by fadd.
   function automatic real to_r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:23] == 8'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] to_f(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
         return 32'hFFC00000;
      return to_f(to_r(a) + to_r(b));
   endfunction

   task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z);
      pend.push_back('{port: p, a: a, b: b});
      exp_q.push_back('{port: p, z: z});
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (pend.size() == 0 && req_stb == '0 && exp_q.size() == 0 && !busy) break;
         n++;
         if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_idle: timeout after %0d cycles, busy=%b pending=%0d", n, busy,
                     exp_q.size());
            break;
         end
      end
   endtask

   // Behavioural adder: accepts A, then B, computes after a random delay, presents Z.
   initial begin : adder_model
      int st, dly;
      logic xa, xb, xz;
      logic [31:0] sa, sb, la, lb;
      st = 0; dly = 0; la = '0; lb = '0;
      adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0; adder_z = '0;
      forever begin
         @(negedge clk);
         xa = adder_a_stb & adder_a_ack;
         xb = adder_b_stb & adder_b_ack;
         xz = adder_z_stb & adder_z_ack;
         sa = adder_a; sb = adder_b;
         @(posedge clk); #1;
         if (rst) begin
            st = 0; adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0;
         end else begin
            case (st)
               0: if (xa) begin la = sa; adder_a_ack = 1'b0; st = 1; end
                  else adder_a_ack = 1'b1;
               1: if (xb) begin
                     lb = sb; adder_b_ack = 1'b0; st = 2; dly = $urandom_range(0, 4);
                  end else adder_b_ack = 1'b1;
               2: if (dly == 0) begin adder_z = fadd(la, lb); adder_z_stb = 1'b1; st = 3; end
                  else dly--;
               default: if (xz) begin adder_z_stb = 1'b0; st = 0; end
            endcase
         end
      end
   end

   // Requester driver: holds each operand pair until its ack transfer, then loads the next.
   initial begin : driver
      logic [NP-1:0] xfer;
      bit found;
      req_stb = '0; req_a = '0; req_b = '0;
      forever begin
         @(negedge clk);
         xfer = req_stb & req_ack;
         @(posedge clk); #1;
         if (rst) begin
            req_stb = '0;
         end else begin
            req_stb = req_stb & ~xfer;
            for (int p = 0; p < NP; p++) begin
               if (!req_stb[p]) begin
                  found = 1'b0;
                  for (int k = 0; k < pend.size(); k++) begin
                     if (!found && pend[k].port == p) begin
                        req_a[32*p +: 32] = pend[k].a;
                        req_b[32*p +: 32] = pend[k].b;
                        req_stb[p] = 1'b1;
                        pend.delete(k);
                        found = 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   // Monitor: invariants every cycle; pops the scoreboard whenever a result is presented.
   initial begin : monitor
      int p, idx;
      res_ack = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            res_ack = '0;
         end else begin
            check("req_ack_onehot0", 32'($onehot0(req_ack)), 32'd1);
            check("res_stb_onehot0", 32'($onehot0(res_stb)), 32'd1);
            check("req_ack_ungranted", 32'(req_ack & ~(NP'(1) << grant)), 32'd0);
            for (int q = 0; q < NP; q++) if (req_stb[q] && req_ack[q]) ack_cnt[q]++;
            if (res_ack != '0) begin
               check("res_done_one_edge", 32'(res_stb & res_ack), 32'd0);
               res_ack = '0;
            end else if (res_stb != '0) begin
               p = 0;
               for (int q = 0; q < NP; q++) if (res_stb[q]) p = q;
               if (!hold_mask[p]) begin
                  check("res_grant", 32'(grant), 32'(p));
                  idx = -1;
                  foreach (exp_q[k]) if (idx < 0 && exp_q[k].port == p) idx = k;
                  if (idx < 0) begin
                     checks++; errors++;
                     $display("FAIL res_unexpected: port %0d got %h expected no result", p, res_z);
                  end else begin
                     check("res_z", res_z, exp_q[idx].z);
                     exp_q.delete(idx);
                  end
                  if (exp_order.size() > 0) check("res_order", 32'(p), 32'(exp_order.pop_front()));
                  res_ack = res_stb;
               end
            end
         end
      end
   end

   initial begin : main
      logic [31:0] z0, a, b;
      int n;
      hold_mask = '0;
      for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", 32'(grant), 32'd3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res_z", res_z, 32'd0);
      check("rst_outs", 32'({req_ack, res_stb, adder_a_stb, adder_b_stb, adder_z_ack}), 32'd0);
      @(negedge clk) rst = 1'b0;

      // Single request from port 0.
      exp_order = '{0};
      issue(0, 32'h3F800000, 32'h40000000, 32'h40400000);
      wait_idle(300);
      check("single_busy", 32'(busy), 32'd0);
      check("single_grant", 32'(grant), 32'd0);

      // Three-way contention held from reset.
      rst = 1'b1;
      for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
      exp_order = '{0, 1, 2};
      issue(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
      issue(1, 32'h40000000, 32'h40000000, 32'h40800000);
      issue(2, 32'h40400000, 32'h40400000, 32'h40C00000);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      wait_idle(600);
      for (int i = 0; i < NP; i++) check("contention_ack_count", 32'(ack_cnt[i]), (i < 3) ? 1 : 0);

      // Rotation: port 3 is next after port 2.
      exp_order = '{3, 0};
      issue(0, 32'hBF800000, 32'h3F800000, 32'h00000000);
      issue(3, 32'h40A00000, 32'h3F800000, 32'h40C00000);
      wait_idle(600);

      // Backpressure on port 1 with port 2 waiting.
      hold_mask = 4'b0010;
      exp_order = '{1, 2};
      issue(1, 32'h40400000, 32'h40800000, 32'h40E00000);
      issue(2, 32'h41200000, 32'h41A00000, 32'h41F00000);
      n = 0;
      do begin @(negedge clk); n++; end while (!res_stb[1] && n < 300);
      check("bp_res_stb_seen", 32'(res_stb), 32'h2);
      z0 = res_z;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_res_stb", 32'(res_stb), 32'h2);
         check("bp_res_z", res_z, z0);
         check("bp_req_ack", 32'(req_ack), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
      end
      hold_mask = '0;
      wait_idle(600);

      // NaN passthrough on port 3.
      exp_order = '{3};
      issue(3, 32'h7FC00000, 32'h3F800000, 32'hFFC00000);
      wait_idle(300);

      // Asynchronous reset while waiting for Z.
      issue(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
      n = 0;
      do begin @(negedge clk); n++; end while (!adder_z_ack && n < 300);
      check("mid_reached_wait_z", 32'(adder_z_ack), 32'd1);
      #3 rst = 1'b1;
      #1;
      check("mid_grant", 32'(grant), 32'd3);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_res_z", res_z, 32'd0);
      check("mid_adder_a", adder_a, 32'd0);
      check("mid_adder_b", adder_b, 32'd0);
      check("mid_outs", 32'({req_ack, res_stb, adder_a_stb, adder_b_stb, adder_z_ack}), 32'd0);
      exp_q.delete();
      exp_order.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      exp_order = '{0};
      issue(0, 32'h40000000, 32'h40400000, 32'h40A00000);
      wait_idle(300);
      check("post_rst_grant", 32'(grant), 32'd0);

      // Randomised traffic on all ports.
      for (int i = 0; i < 40; i++) begin
         a = to_f(real'(int'($urandom_range(0, 2000)) - 1000));
         b = to_f(real'(int'($urandom_range(0, 2000)) - 1000));
         n = int'($urandom_range(0, NP - 1));
         issue(n, a, b, fadd(a, b));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge clk);
      end
      wait_idle(20000);
      check("end_pending", 32'(pend.size()), 32'd0);
      check("end_scoreboard", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
